// File: rtl/rgmii_tx_framer.sv
// rtl/rgmii_tx_framer.sv - RGMII TX framer: preamble/SFD, zero pad, optional FCS, IFG, DDR pins
// Optional feature macro CRC_APPEND_EN: append CRC-32 FCS; undefined means the stream carries its own FCS.
module rgmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       tx_underrun,
  output logic       rgmii_txc,
  output logic       rgmii_tx_ctl,
  output logic [3:0] rgmii_txd
);

`ifdef CRC_APPEND_EN
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;
  localparam state_t BODY_DONE = FCS;
`else
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, IFG} state_t;
  localparam state_t BODY_DONE = IFG;
`endif

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, byte_inc;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic [3:0]  ddr_rise_q, ddr_rise_d, ddr_fall_q, ddr_fall_d;
  logic        ddr_ctl_q, ddr_ctl_d;

`ifdef CRC_APPEND_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction
`endif

  assign byte_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    in_ready    = 1'b0;
    tx_busy     = (state_q != IDLE);
    frame_done  = 1'b0;
    tx_underrun = 1'b0;
    ddr_rise_d  = txd_q[3:0];
    ddr_fall_d  = txd_q[7:4];
    ddr_ctl_d   = tx_en_q;
`ifdef CRC_APPEND_EN
    crc_d       = crc_q;
`endif
    case (state_q)
      IDLE: begin
        byte_cnt_d = 16'd0;
        cnt_d      = 8'd0;
`ifdef CRC_APPEND_EN
        crc_d      = 32'hFFFF_FFFF;
`endif
        // The first preamble byte goes out on the same edge that sees in_valid.
        if (in_valid) begin
          state_d = PRE;
          txd_d   = 8'h55;
          tx_en_d = 1'b1;
          cnt_d   = 8'd1;
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q < PRE_LAST) begin
          txd_d = 8'h55;
          cnt_d = cnt_q + 8'd1;
        end else begin
          txd_d   = 8'hD5;
          state_d = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          txd_d      = in_data;
          tx_en_d    = 1'b1;
          byte_cnt_d = byte_inc;
`ifdef CRC_APPEND_EN
          crc_d      = crc32_byte(crc_q, in_data);
`endif
          if (in_last) begin
            cnt_d   = 8'd0;
            state_d = (byte_inc < MIN_LEN) ? PAD : BODY_DONE;
          end
        end else begin
          // Underrun abandons the frame: no pad, no FCS, straight to the gap.
          tx_underrun = 1'b1;
          cnt_d       = 8'd0;
          state_d     = IFG;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        byte_cnt_d = byte_inc;
`ifdef CRC_APPEND_EN
        crc_d      = crc32_byte(crc_q, 8'h00);
`endif
        if (byte_inc >= MIN_LEN) state_d = BODY_DONE;
      end
`ifdef CRC_APPEND_EN
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = ~crc_q[7:0];
        crc_d   = {8'h00, crc_q[31:8]};
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'd3) begin
          cnt_d   = 8'd0;
          state_d = IFG;
        end
      end
`endif
      IFG: begin
        // First IFG cycle still shows the final byte; the IDLE cycle completes the gap.
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == IFG_LAST) begin
          frame_done = 1'b1;
          cnt_d      = 8'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 16'd0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      ddr_rise_q <= 4'h0;
      ddr_fall_q <= 4'h0;
      ddr_ctl_q  <= 1'b0;
`ifdef CRC_APPEND_EN
      crc_q      <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      ddr_rise_q <= ddr_rise_d;
      ddr_fall_q <= ddr_fall_d;
      ddr_ctl_q  <= ddr_ctl_d;
`ifdef CRC_APPEND_EN
      crc_q      <= crc_d;
`endif
    end
  end

  // Behavioural DDR output: low nibble while the clock is high, high nibble while low.
  assign rgmii_txc    = gmii_tx_clk;
  assign rgmii_tx_ctl = ddr_ctl_q;
  assign rgmii_txd    = gmii_tx_clk ? ddr_rise_q : ddr_fall_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb/tb_rgmii_tx_framer.sv - directed bench for rgmii_tx_framer; instance a has MIN_PAYLOAD 0, instance b 60
`timescale 1ns/1ps
module tb_rgmii_tx_framer;
  localparam int LOGN = 2048;
`ifdef CRC_APPEND_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] iv, il, ird, busy_o, done_o, und_o, txc_o, ctl_o;
  logic [1:0][7:0] idt;
  logic [1:0][3:0] txd_o;

  always #4 clk = ~clk;

  rgmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_PAYLOAD(0), .IFG_CYCLES(12)) dut_a (
    .gmii_tx_clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idt[0]), .in_last(il[0]),
    .in_ready(ird[0]), .tx_busy(busy_o[0]), .frame_done(done_o[0]), .tx_underrun(und_o[0]),
    .rgmii_txc(txc_o[0]), .rgmii_tx_ctl(ctl_o[0]), .rgmii_txd(txd_o[0]));

  rgmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_PAYLOAD(60), .IFG_CYCLES(12)) dut_b (
    .gmii_tx_clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idt[1]), .in_last(il[1]),
    .in_ready(ird[1]), .tx_busy(busy_o[1]), .frame_done(done_o[1]), .tx_underrun(und_o[1]),
    .rgmii_txc(txc_o[1]), .rgmii_tx_ctl(ctl_o[1]), .rgmii_txd(txd_o[1]));

  // Per-cycle log: wire nibbles/ctl per edge, and status outputs mid-cycle.
  int cyc = 0;
  logic [3:0] wlo [2][LOGN];
  logic [3:0] whi [2][LOGN];
  logic wr [2][LOGN];
  logic wf [2][LOGN];
  logic rdy_l [2][LOGN];
  logic busy_l [2][LOGN];
  logic done_l [2][LOGN];
  logic und_l [2][LOGN];
  logic [1:0][3:0] lo_s;
  logic [1:0] cr_s;

  always begin
    @(posedge clk); #1;
    lo_s = txd_o;
    cr_s = ctl_o;
    @(negedge clk); #1;
    if (cyc < LOGN) begin
      for (int s = 0; s < 2; s++) begin
        wlo[s][cyc]    = lo_s[s];
        whi[s][cyc]    = txd_o[s];
        wr[s][cyc]     = cr_s[s];
        wf[s][cyc]     = ctl_o[s];
        rdy_l[s][cyc]  = ird[s];
        busy_l[s][cyc] = busy_o[s];
        done_l[s][cyc] = done_o[s];
        und_l[s][cyc]  = und_o[s];
      end
    end
    cyc++;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic logic [7:0] wb(input int s, input int c);
    return {whi[s][c], wlo[s][c]};
  endfunction

  function automatic int run_en(input int s, input int c);
    int n = 0;
    while (c + n < LOGN && n < 300 && wr[s][c+n] === 1'b1 && wf[s][c+n] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_seq(input int s, input int c, input int n,
                                   input logic [7:0] first, input logic [7:0] inc);
    int m = 0;
    for (int k = 0; k < n && c + k < LOGN; k++)
      if (wr[s][c+k] === 1'b1 && wb(s, c+k) === first + 8'(k) * inc) m++;
    return m;
  endfunction

  // kind: 0 in_ready, 1 tx_busy, 2 frame_done, 3 tx_underrun, 4 ctl on either edge, 5 ctl edges differ
  function automatic int count_flag(input int s, input int kind, input int c0, input int c1);
    int m = 0;
    logic f;
    for (int c = c0; c <= c1 && c < LOGN; c++) begin
      case (kind)
        0:       f = rdy_l[s][c];
        1:       f = busy_l[s][c];
        2:       f = done_l[s][c];
        3:       f = und_l[s][c];
        4:       f = wr[s][c] | wf[s][c];
        default: f = wr[s][c] ^ wf[s][c];
      endcase
      if (f === 1'b1) m++;
    end
    return m;
  endfunction

  task automatic send(input int s, input logic [7:0] base, input int n, input int cut,
                      input bit hold, input logic [7:0] next_base, output int t0, output int tc);
    int k;
    int guard;
    bit acc;
    k = 0;
    guard = 0;
    t0 = cyc;
    tc = -1;
    iv[s] = 1'b1;
    idt[s] = base;
    il[s] = (n == 1);
    while (k < n && guard < 400) begin
      @(negedge clk); #1;
      acc = iv[s] & ird[s];
      @(posedge clk); #2;
      guard++;
      if (acc) begin
        k++;
        idt[s] = base + 8'(k);
        il[s] = (k == n - 1);
        if (cut > 0 && k == cut) begin
          iv[s] = 1'b0;
          il[s] = 1'b0;
          tc = cyc;
          break;
        end
      end
    end
    chk("send_accepted", k, (cut > 0) ? cut : n);
    if (tc < 0) begin
      iv[s] = hold;
      il[s] = 1'b0;
      idt[s] = hold ? next_base : 8'h00;
    end
  endtask

  int t0, tc, e, g, f1, l1, t1;

  initial begin
    rst = 1'b1;
    iv = '0;
    il = '0;
    idt = '0;
    tick(3);
    chk("rst_in_ready", ird, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_underrun", und_o, 0);
    chk("rst_pins", {ctl_o, txd_o}, 0);
    rst = 1'b0;
    tick(2);
    chk("idle_pins", {ctl_o, txd_o, busy_o}, 0);
    chk("txc_follows_clk", txc_o, 2'b11);

    // 1: "123456789", no pad
    send(0, 8'h31, 9, 0, 1'b0, 8'h00, t0, tc);
    tick(40);
    e = t0 + 19 + FCS_N;
    chk("t1_quiet_before", count_flag(0, 4, t0, t0 + 1), 0);
    chk("t1_preamble", count_seq(0, t0 + 2, 7, 8'h55, 8'h00), 7);
    chk("t1_sfd", wb(0, t0 + 9), 8'hD5);
    chk("t1_data", count_seq(0, t0 + 10, 9, 8'h31, 8'h01), 9);
`ifdef CRC_APPEND_EN
    chk("t1_fcs", {wb(0, t0 + 19), wb(0, t0 + 20), wb(0, t0 + 21), wb(0, t0 + 22)}, 32'h2639F4CB);
`endif
    chk("t1_en_len", run_en(0, t0 + 2), 17 + FCS_N);
    chk("t1_ifg_quiet", count_flag(0, 4, e, e + 11), 0);
    chk("t1_ctl_edges", count_flag(0, 5, t0, e + 12), 0);
    chk("t1_rdy_rise", {rdy_l[0][t0 + 7], rdy_l[0][t0 + 8]}, 2'b01);
    chk("t1_rdy_cycles", count_flag(0, 0, t0, e + 12), 9);
    chk("t1_busy_edges", {busy_l[0][t0], busy_l[0][t0 + 1], busy_l[0][e + 9], busy_l[0][e + 10]}, 4'b0110);
    chk("t1_done_at", done_l[0][e + 9], 1);
    chk("t1_done_cnt", count_flag(0, 2, t0, e + 12), 1);
    chk("t1_no_underrun", count_flag(0, 3, t0, e + 12), 0);

    // 2 and 6: 4-byte frame padded to 60, DDR nibble order
    send(1, 8'hA5, 4, 0, 1'b0, 8'h00, t0, tc);
    tick(100);
    e = t0 + 70 + FCS_N;
    chk("t2_sfd", wb(1, t0 + 9), 8'hD5);
    chk("t2_data", count_seq(1, t0 + 10, 4, 8'hA5, 8'h01), 4);
    chk("t6_ddr_rise", wlo[1][t0 + 10], 4'h5);
    chk("t6_ddr_fall", whi[1][t0 + 10], 4'hA);
    chk("t6_ctl_both", {wr[1][t0 + 10], wf[1][t0 + 10]}, 2'b11);
    chk("t2_pad", count_seq(1, t0 + 14, 56, 8'h00, 8'h00), 56);
    chk("t2_en_len", run_en(1, t0 + 2), 68 + FCS_N);
    chk("t2_ifg_quiet", count_flag(1, 4, e, e + 11), 0);
    chk("t2_done_at", done_l[1][e + 9], 1);
    chk("t2_done_cnt", count_flag(1, 2, t0, e + 12), 1);

    // 3: back-to-back with in_valid held through the gap
    send(1, 8'h10, 4, 0, 1'b1, 8'h20, t1, tc);
    send(1, 8'h20, 4, 0, 1'b0, 8'h00, t0, tc);
    tick(100);
    f1 = t1 + 2;
    l1 = run_en(1, f1);
    g = f1 + l1;
    chk("t3_len1", l1, 68 + FCS_N);
    chk("t3_gap_quiet", count_flag(1, 4, g, g + 11), 0);
    chk("t3_gap_rdy", count_flag(1, 0, g - 1, g + 10), 0);
    chk("t3_next_pre", wb(1, g + 12), 8'h55);
    chk("t3_len2", run_en(1, g + 12), 68 + FCS_N);
    chk("t3_sfd2", wb(1, g + 19), 8'hD5);
    chk("t3_data2", count_seq(1, g + 20, 4, 8'h20, 8'h01), 4);
    chk("t3_done_cnt", count_flag(1, 2, t1, g + 12 + 68 + FCS_N + 12), 2);

    // 4: underrun after 10 of 20 bytes
    send(0, 8'h40, 20, 10, 1'b0, 8'h00, t0, tc);
    tick(30);
    chk("t4_cut_cycle", tc, t0 + 18);
    chk("t4_underrun_at", und_l[0][tc], 1);
    chk("t4_underrun_cnt", count_flag(0, 3, t0, tc + 20), 1);
    chk("t4_last_byte", {wr[0][tc + 1], wb(0, tc + 1)}, {1'b1, 8'h49});
    chk("t4_quiet_after", count_flag(0, 4, tc + 2, tc + 20), 0);
    chk("t4_en_len", run_en(0, t0 + 2), 18);
    chk("t4_done_busy", {done_l[0][tc + 12], busy_l[0][tc + 12], busy_l[0][tc + 13]}, 3'b110);

    // 5: reset during DATA
    iv[0] = 1'b1;
    idt[0] = 8'h70;
    il[0] = 1'b0;
    t0 = cyc;
    tick(14);
    chk("t5_mid_frame", {wr[0][t0 + 13], wb(0, t0 + 13)}, {1'b1, 8'h70});
    rst = 1'b1;
    #1;
    chk("t5_rst_pins", {ctl_o[0], txd_o[0]}, 0);
    chk("t5_rst_status", {ird[0], busy_o[0], und_o[0], done_o[0]}, 0);
    iv[0] = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("t5_idle_after", {busy_o[0], ctl_o[0]}, 0);
    send(0, 8'h60, 3, 0, 1'b0, 8'h00, t0, tc);
    tick(30);
    chk("t5_preamble", count_seq(0, t0 + 2, 7, 8'h55, 8'h00), 7);
    chk("t5_data", count_seq(0, t0 + 10, 3, 8'h60, 8'h01), 3);
    chk("t5_en_len", run_en(0, t0 + 2), 11 + FCS_N);
    chk("t5_done_cnt", count_flag(0, 2, t0, t0 + 30), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

endmodule
